// File: rtl/wb_sram_responder.sv
// Wishbone B4 pipelined SRAM responder with fixed ack latency and programmable stall.
// Define WB_RESPONDER_ERR_EN to error-terminate requests with nonzero upper address bits.
module wb_sram_responder #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STALL_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_ACCEPT,
        ST_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    accept;
    logic                    req_err;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [31:0]             mem_q [DEPTH];
    logic [LATENCY-1:0]      vld_q, vld_d;
    logic [LATENCY-1:0]      err_q, err_d;
    logic [31:0]             dat_q [LATENCY];
    logic [31:0]             dat_d [LATENCY];
    logic                    unused_adr;

    assign wb_stall_o = (state_q == ST_HOLD);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign word_idx   = wb_adr_i[ADDR_WIDTH+1:2];

`ifdef WB_RESPONDER_ERR_EN
    assign req_err    = |wb_adr_i[31:ADDR_WIDTH+2];
    assign unused_adr = ^wb_adr_i[1:0];
`else
    assign req_err    = 1'b0;
    assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};
`endif

    // Stall FSM: counter holds remaining HOLD cycles minus one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!wb_cyc_i) begin
            state_d = ST_ACCEPT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (accept && (STALL_CYCLES != 0)) begin
                        state_d = ST_HOLD;
                        cnt_d   = 3'(STALL_CYCLES - 1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 3'd0) begin
                        state_d = ST_ACCEPT;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_ACCEPT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        vld_d = '0;
        err_d = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            dat_d[i] = '0;
        end
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        vld_d[0] = accept;
        err_d[0] = accept & req_err;
        if (accept && !wb_we_i && !req_err) begin
            dat_d[0] = mem_q[word_idx];
        end
        // Dropping CYC abandons every outstanding response.
        if (!wb_cyc_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_ACCEPT;
            cnt_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Storage is deliberately not reset; writes are blocked while in reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept && wb_we_i && !req_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb_ack_o = vld_q[LATENCY-1] & ~err_q[LATENCY-1];
`ifdef WB_RESPONDER_ERR_EN
    assign wb_err_o = vld_q[LATENCY-1] & err_q[LATENCY-1];
`else
    assign wb_err_o = 1'b0;
`endif
    assign wb_dat_o = wb_ack_o ? dat_q[LATENCY-1] : '0;

endmodule
